// File: rtl/traffic_phase_arbiter_if.sv
// Bundles the junction request inputs and the lamp/status outputs of traffic_phase_arbiter.
// The arbiter connects through the slave modport; the driving side uses master.
interface traffic_phase_arbiter_if;
   logic       enable;
   logic [3:0] req;
   logic [2:0] road1_out;
   logic [2:0] road2_out;
   logic [2:0] road3_out;
   logic [2:0] ped;
   logic [1:0] grant;
   logic       busy;
   logic [3:0] pend;

   modport slave (
      input  enable, req,
      output road1_out, road2_out, road3_out, ped, grant, busy, pend
   );

   modport master (
      output enable, req,
      input  road1_out, road2_out, road3_out, ped, grant, busy, pend
   );
endinterface

// File: rtl/traffic_phase_arbiter.sv
// Round-robin phase scheduler for a 3-road + pedestrian junction.
// Each granted phase runs GREEN -> YELLOW -> ALL_RED; lamps are a Moore decode of state and grant.
module traffic_phase_arbiter #(
   parameter int unsigned TMR_W       = 6,
   parameter int unsigned GREEN_TIME  = 10,
   parameter int unsigned MAX_GREEN   = 20,
   parameter int unsigned YELLOW_TIME = 2,
   parameter int unsigned ALLRED_TIME = 1
) (
   input logic                  clk,
   input logic                  rst,
   traffic_phase_arbiter_if.slave bus
);

   localparam logic [2:0] LampRed = 3'b001;
   localparam logic [2:0] LampYel = 3'b010;
   localparam logic [2:0] LampGrn = 3'b100;

   localparam logic [TMR_W-1:0] GreenLast  = TMR_W'(GREEN_TIME - 1);
   localparam logic [TMR_W-1:0] MaxGrnLast = TMR_W'(MAX_GREEN - 1);
   localparam logic [TMR_W-1:0] YellowLast = TMR_W'(YELLOW_TIME - 1);
   localparam logic [TMR_W-1:0] AllRedLast = TMR_W'(ALLRED_TIME - 1);

   typedef enum logic [1:0] {StIdle, StAllRed, StGreen, StYellow} state_e;

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [1:0]       grant_q, grant_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [3:0]       pend_q, pend_d;

   logic [1:0] pick;
   logic [1:0] cand;
   logic       pick_found;
   logic [3:0] others_pend;
   logic       extend;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         timer_q <= '0;
         grant_q <= 2'd0;
         ptr_q   <= 2'd3;
         pend_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
      end
   end

   // First pending phase after the last one served, wrapping modulo 4.
   always_comb begin
      pick       = ptr_q;
      cand       = ptr_q;
      pick_found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!pick_found && pend_q[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   assign others_pend = pend_q & ~(4'b0001 << grant_q);
   assign extend      = bus.req[grant_q] && (others_pend == 4'b0000) && bus.enable &&
                        (timer_q < MaxGrnLast);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      pend_d  = pend_q | bus.req;
      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (bus.enable) state_d = StAllRed;
         end
         StAllRed: begin
            if (timer_q >= AllRedLast) begin
               if (!bus.enable) begin
                  state_d = StIdle;
                  timer_d = '0;
               end else if (pend_q != 4'b0000) begin
                  state_d      = StGreen;
                  timer_d      = '0;
                  grant_d      = pick;
                  ptr_d        = pick;
                  // A request arriving on the grant cycle is absorbed by this grant.
                  pend_d[pick] = 1'b0;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         StGreen: begin
            if (timer_q >= GreenLast && !extend) begin
               state_d = StYellow;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         StYellow: begin
            if (timer_q >= YellowLast) begin
               state_d = StAllRed;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   logic [2:0] lamp [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lamp[i] = LampRed;
         if (grant_q == 2'(i)) begin
            if (state_q == StGreen)  lamp[i] = LampGrn;
            if (state_q == StYellow) lamp[i] = LampYel;
         end
      end
   end

   assign bus.road1_out = lamp[0];
   assign bus.road2_out = lamp[1];
   assign bus.road3_out = lamp[2];
   assign bus.ped       = lamp[3];
   assign bus.grant     = (state_q == StGreen || state_q == StYellow) ? grant_q : 2'd0;
   assign bus.busy      = (state_q != StIdle);
   assign bus.pend      = pend_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed bench for traffic_phase_arbiter: phase timing, round-robin order, extension,
// enable drain and reset, with a per-cycle lamp invariant monitor.
module tb_traffic_phase_arbiter;

   localparam logic [2:0] RED = 3'b001;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   traffic_phase_arbiter_if bus ();

   traffic_phase_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] lamp(input int ph);
      case (ph)
         0:       return bus.road1_out;
         1:       return bus.road2_out;
         2:       return bus.road3_out;
         default: return bus.ped;
      endcase
   endfunction

   // Every bus one-hot, at most one bus non-RED, every cycle.
   always @(negedge clk) begin
      int nonred;
      nonred = 0;
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("onehot%0d", i), 32'($countones(lamp(i))), 32'd1);
         if (lamp(i) != RED) nonred++;
      end
      check_eq("one_nonred", 32'(nonred <= 1), 32'd1);
   end

   task automatic do_reset();
      rst        = 1'b1;
      bus.enable = 1'b0;
      bus.req    = 4'b0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // wait_c: cycles stepped before green seen; then green and yellow lengths.
   task automatic measure(input int ph, output int wait_c, output int g_c, output int y_c,
                          output logic [1:0] g_idx);
      wait_c = 0;
      g_c    = 0;
      y_c    = 0;
      g_idx  = 2'd0;
      while (lamp(ph) != GRN && wait_c < 100) begin
         @(negedge clk);
         wait_c++;
      end
      if (wait_c >= 100) begin
         check_eq($sformatf("green_timeout%0d", ph), 32'd0, 32'd1);
         return;
      end
      g_idx = bus.grant;
      while (lamp(ph) == GRN && g_c < 100) begin
         g_c++;
         @(negedge clk);
      end
      while (lamp(ph) == YEL && y_c < 100) begin
         y_c++;
         @(negedge clk);
      end
   endtask

   initial begin
      int         w, g, y, a;
      logic [1:0] gi;
      int         order [5] = '{0, 1, 2, 3, 0};

      // 1: reset holds pend clear despite req, then IDLE latches req
      bus.enable = 1'b0;
      bus.req    = 4'b1111;
      repeat (2) @(negedge clk);
      check_eq("rst_pend", 32'(bus.pend), 32'h0);
      check_eq("rst_busy", 32'(bus.busy), 32'h0);
      check_eq("rst_grant", 32'(bus.grant), 32'h0);
      check_eq("rst_r1", 32'(bus.road1_out), 32'(RED));
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_pend", 32'(bus.pend), 32'hf);
      bus.req = 4'b0000;
      repeat (3) @(negedge clk);
      check_eq("idle_pend_held", 32'(bus.pend), 32'hf);
      check_eq("idle_busy", 32'(bus.busy), 32'h0);
      check_eq("idle_ped", 32'(bus.ped), 32'(RED));

      // 2: single road1 pulse
      do_reset();
      bus.enable = 1'b1;
      bus.req    = 4'b0001;
      @(negedge clk);
      check_eq("t2_pend_latched", 32'(bus.pend), 32'h1);
      check_eq("t2_busy", 32'(bus.busy), 32'h1);
      bus.req = 4'b0000;
      measure(0, w, g, y, gi);
      check_eq("t2_wait", 32'(w), 32'd1);
      check_eq("t2_green", 32'(g), 32'd10);
      check_eq("t2_yellow", 32'(y), 32'd2);
      check_eq("t2_grant", 32'(gi), 32'd0);
      check_eq("t2_pend_cleared", 32'(bus.pend), 32'h0);
      repeat (3) @(negedge clk);
      check_eq("t2_allred_r1", 32'(bus.road1_out), 32'(RED));
      check_eq("t2_allred_busy", 32'(bus.busy), 32'h1);

      // 3: all requests held -> strict round robin, no extension
      do_reset();
      bus.enable = 1'b1;
      bus.req    = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         measure(order[k], w, g, y, gi);
         check_eq($sformatf("t3_grant%0d", k), 32'(gi), 32'(order[k]));
         check_eq($sformatf("t3_green%0d", k), 32'(g), 32'd10);
         check_eq($sformatf("t3_yellow%0d", k), 32'(y), 32'd2);
         if (k > 0) check_eq($sformatf("t3_allred%0d", k), 32'(w), 32'd1);
      end

      // 4: lone road3 request extends to the cap and is re-granted
      do_reset();
      bus.enable = 1'b1;
      bus.req    = 4'b0100;
      for (int k = 0; k < 2; k++) begin
         measure(2, w, g, y, gi);
         check_eq($sformatf("t4_grant%0d", k), 32'(gi), 32'd2);
         check_eq($sformatf("t4_green%0d", k), 32'(g), 32'd20);
         check_eq($sformatf("t4_yellow%0d", k), 32'(y), 32'd2);
         if (k > 0) check_eq("t4_regrant_wait", 32'(w), 32'd1);
      end

      // 5: enable dropped in cycle 3 of ped green
      do_reset();
      bus.enable = 1'b1;
      bus.req    = 4'b1000;
      w = 0;
      while (bus.ped != GRN && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq("t5_ped_green_seen", 32'(bus.ped), 32'(GRN));
      g = 0;
      while (bus.ped == GRN && g < 100) begin
         g++;
         if (g == 3) bus.enable = 1'b0;
         @(negedge clk);
      end
      y = 0;
      while (bus.ped == YEL && y < 100) begin
         y++;
         @(negedge clk);
      end
      a = 0;
      while (bus.busy && a < 100) begin
         a++;
         @(negedge clk);
      end
      check_eq("t5_green", 32'(g), 32'd10);
      check_eq("t5_yellow", 32'(y), 32'd2);
      check_eq("t5_allred", 32'(a), 32'd1);
      check_eq("t5_idle_ped", 32'(bus.ped), 32'(RED));
      check_eq("t5_idle_grant", 32'(bus.grant), 32'h0);

      // 6: reset during yellow, with requests still asserted
      do_reset();
      bus.enable = 1'b1;
      bus.req    = 4'b0010;
      @(negedge clk);
      bus.req = 4'b1101;
      w = 0;
      while (bus.road2_out != YEL && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq("t6_yellow_seen", 32'(bus.road2_out), 32'(YEL));
      check_eq("t6_yellow_grant", 32'(bus.grant), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t6_r2", 32'(bus.road2_out), 32'(RED));
      check_eq("t6_grant", 32'(bus.grant), 32'h0);
      check_eq("t6_pend", 32'(bus.pend), 32'h0);
      check_eq("t6_busy", 32'(bus.busy), 32'h0);
      rst     = 1'b0;
      bus.req = 4'b0000;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
